// File: rtl/canxl_pkg.sv
// canxl_pkg: CAN XL prefix-CRC constants, PCRC state type and the LFSR step shared
// by the TX generator and the RX checker.
package canxl_pkg;

  localparam int CRC_W = 13;
  localparam logic [CRC_W-1:0] PCRC_POLY = 13'h19C7;
  localparam logic [CRC_W-1:0] PCRC_INIT = 13'h0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    SEND  = 2'd2,
    DONE  = 2'd3
  } pcrc_state_t;

  // One serial CRC step; the x^13 term is implicit in the feedback.
  function automatic logic [CRC_W-1:0] pcrc_step(
    input logic [CRC_W-1:0] crc,
    input logic             din,
    input logic [CRC_W-1:0] poly = PCRC_POLY
  );
    logic fb;
    fb = din ^ crc[CRC_W-1];
    return {crc[CRC_W-2:0], 1'b0} ^ (fb ? poly : '0);
  endfunction

endpackage

// File: rtl/canxl_tx_pcrc_ser.sv
// canxl_tx_pcrc_ser: MSB-first CRC shift register with bit counter and a
// one-cycle done pulse after the last bit has been strobed out.
module canxl_tx_pcrc_ser
  import canxl_pkg::*;
(
  input  logic             clk,
  input  logic             g_rst,
  input  logic             i_clear,
  input  logic             i_load,
  input  logic [CRC_W-1:0] i_load_val,
  input  logic             i_shift,
  output logic             o_msb,
  output logic             o_last,
  output logic             o_done
);

  localparam logic [3:0] CNT_LAST_IDX = 4'(CRC_W - 1);

  logic [CRC_W-1:0] r_shreg;
  logic [3:0]       r_cnt;
  logic             r_done;

  // NOTE: sequential state is written with non-blocking assignments only, so every
  // register samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge g_rst) begin
    if (g_rst) begin
      r_shreg <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_clear) begin
        r_shreg <= '0;
        r_cnt   <= '0;
      end else if (i_load) begin
        r_shreg <= i_load_val;
        r_cnt   <= CNT_LAST_IDX;
      end else if (i_shift) begin
        r_shreg <= {r_shreg[CRC_W-2:0], 1'b0};
        if (r_cnt != '0) begin
          r_cnt <= r_cnt - 4'd1;
        end
        r_done <= (r_cnt == '0);
      end
    end
  end

  assign o_msb  = r_shreg[CRC_W-1];
  assign o_last = (r_cnt == '0);
  assign o_done = r_done;

endmodule

// File: rtl/canxl_tx_pcrc.sv
// canxl_tx_pcrc: TX-side CAN XL prefix-CRC accumulator and MSB-first serializer.
// Define CANXL_TX_PCRC_READBACK_EN to add the sticky bus readback comparator.
module canxl_tx_pcrc
  import canxl_pkg::*;
#(
  parameter logic [CRC_W-1:0] CRC_POLY = PCRC_POLY,
  parameter logic [CRC_W-1:0] CRC_INIT = PCRC_INIT
) (
  input  logic             clk,
  input  logic             g_rst,
  input  logic             initialize,
  input  logic             tx_success,
  input  logic             rx_success,
  input  logic             tx_abort,
  input  logic             tx_bit_strobe,
  input  logic             tx_bit,
  input  logic             pcrc_enable,
  input  logic             pcrc_send,
  input  logic             rx_bit,
  output logic [CRC_W-1:0] pcrc_frm,
  output logic             pcrc_out_bit,
  output logic             pcrc_out_valid,
  output logic             pcrc_done,
  output logic             pcrc_bit_err
);

  pcrc_state_t      r_state;
  pcrc_state_t      w_state_nxt;
  logic [CRC_W-1:0] r_crc;
  logic [CRC_W-1:0] w_crc_next;
  logic             w_clear;
  logic             w_restart;
  logic             w_accum_bit;
  logic             w_ser_load;
  logic             w_ser_shift;
  logic             w_ser_msb;
  logic             w_ser_last;
  logic             w_ser_done;

  // Frame-end clears outrank initialize, which outranks send and strobes.
  assign w_clear     = tx_success | rx_success | tx_abort;
  assign w_restart   = w_clear | initialize;
  assign w_accum_bit = (r_state == ACCUM) && tx_bit_strobe && pcrc_enable;
  assign w_crc_next  = w_accum_bit ? pcrc_step(r_crc, tx_bit, CRC_POLY) : r_crc;
  assign w_ser_load  = (r_state == ACCUM) && pcrc_send && !w_restart;
  assign w_ser_shift = (r_state == SEND) && tx_bit_strobe && !w_restart;

  always_ff @(posedge clk or posedge g_rst) begin
    if (g_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // NOTE: the default assignment first means every path drives w_state_nxt, so no latch.
  always_comb begin
    w_state_nxt = r_state;
    if (w_clear) begin
      w_state_nxt = IDLE;
    end else if (initialize) begin
      w_state_nxt = ACCUM;
    end else begin
      case (r_state)
        ACCUM:   if (pcrc_send) w_state_nxt = SEND;
        SEND:    if (w_ser_shift && w_ser_last) w_state_nxt = DONE;
        default: ;
      endcase
    end
  end

  always_comb begin
    pcrc_out_valid = (r_state == SEND);
    pcrc_out_bit   = pcrc_out_valid & w_ser_msb;
  end

  // Only ACCUM updates the CRC, so it stays frozen through SEND and DONE.
  always_ff @(posedge clk or posedge g_rst) begin
    if (g_rst) begin
      r_crc <= CRC_INIT;
    end else if (w_restart) begin
      r_crc <= CRC_INIT;
    end else if (r_state == ACCUM) begin
      r_crc <= w_crc_next;
    end
  end

  canxl_tx_pcrc_ser u_ser (
    .clk        (clk),
    .g_rst      (g_rst),
    .i_clear    (w_restart),
    .i_load     (w_ser_load),
    .i_load_val (w_crc_next),
    .i_shift    (w_ser_shift),
    .o_msb      (w_ser_msb),
    .o_last     (w_ser_last),
    .o_done     (w_ser_done)
  );

  assign pcrc_frm  = r_crc;
  assign pcrc_done = w_ser_done;

`ifdef CANXL_TX_PCRC_READBACK_EN
  logic r_bit_err;

  always_ff @(posedge clk or posedge g_rst) begin
    if (g_rst) begin
      r_bit_err <= 1'b0;
    end else if (w_restart) begin
      r_bit_err <= 1'b0;
    end else if (w_ser_shift && (rx_bit != w_ser_msb)) begin
      r_bit_err <= 1'b1;
    end
  end

  assign pcrc_bit_err = r_bit_err;
`else
  logic w_unused_rx_bit;
  assign w_unused_rx_bit = rx_bit;
  assign pcrc_bit_err    = 1'b0;
`endif

endmodule

// File: tb/tb_canxl_tx_pcrc.sv
// tb_canxl_tx_pcrc: directed table, hand-written corner sequences and random frames
// checked against a polynomial long-division model of the prefix CRC.
module tb_canxl_tx_pcrc;

  logic        clk = 1'b0;
  logic        g_rst;
  logic        initialize, tx_success, rx_success, tx_abort;
  logic        tx_bit_strobe, tx_bit, pcrc_enable, pcrc_send, rx_bit;
  logic [12:0] pcrc_frm;
  logic        pcrc_out_bit, pcrc_out_valid, pcrc_done, pcrc_bit_err;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef CANXL_TX_PCRC_READBACK_EN
  localparam bit READBACK = 1'b1;
`else
  localparam bit READBACK = 1'b0;
`endif

  always #5 clk = ~clk;

  canxl_tx_pcrc dut (
    .clk            (clk),
    .g_rst          (g_rst),
    .initialize     (initialize),
    .tx_success     (tx_success),
    .rx_success     (rx_success),
    .tx_abort       (tx_abort),
    .tx_bit_strobe  (tx_bit_strobe),
    .tx_bit         (tx_bit),
    .pcrc_enable    (pcrc_enable),
    .pcrc_send      (pcrc_send),
    .rx_bit         (rx_bit),
    .pcrc_frm       (pcrc_frm),
    .pcrc_out_bit   (pcrc_out_bit),
    .pcrc_out_valid (pcrc_out_valid),
    .pcrc_done      (pcrc_done),
    .pcrc_bit_err   (pcrc_bit_err)
  );

  // clr: 0 none, 1 tx_success, 2 rx_success, 3 tx_abort
  typedef struct {
    logic        ini;
    logic        snd;
    logic        stb;
    logic        b;
    logic        en;
    logic [1:0]  clr;
    logic [12:0] frm;
    logic        valid;
    logic        obit;
    logic        done;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic ini, input logic snd, input logic stb,
                              input logic b, input logic en, input logic [1:0] clr,
                              input logic [12:0] frm, input logic valid,
                              input logic obit, input logic done);
    vec_t v;
    v.ini = ini; v.snd = snd; v.stb = stb; v.b = b; v.en = en; v.clr = clr;
    v.frm = frm; v.valid = valid; v.obit = obit; v.done = done;
    return v;
  endfunction

  // Remainder of M(x)*x^13 divided by x^13 + 0x19C7 (zero initial value).
  function automatic logic [12:0] ref_crc(input bit msg[$]);
    int unsigned rem;
    rem = 0;
    for (int i = 0; i < msg.size() + 13; i++) begin
      rem = (rem << 1) | ((i < msg.size()) ? 32'(msg[i]) : 32'd0);
      if (rem[13]) rem = rem ^ 32'h39C7;
    end
    return rem[12:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ini, input logic snd, input logic stb,
                       input logic b, input logic en, input logic [1:0] clr);
    initialize    = ini;
    pcrc_send     = snd;
    tx_bit_strobe = stb;
    tx_bit        = b;
    pcrc_enable   = en;
    tx_success    = (clr == 2'd1);
    rx_success    = (clr == 2'd2);
    tx_abort      = (clr == 2'd3);
    @(posedge clk);
    #1;
    initialize = 1'b0; pcrc_send = 1'b0; tx_bit_strobe = 1'b0; tx_bit = 1'b0;
    pcrc_enable = 1'b0; tx_success = 1'b0; rx_success = 1'b0; tx_abort = 1'b0;
  endtask

  // Called right after SEND entry; strobes out 13 bits and checks each one.
  task automatic serialize_check(input string tag, input logic [12:0] exp_crc, input bit gaps);
    int n_early_done;
    n_early_done = 0;
    for (int j = 0; j < 13; j++) begin
      if (gaps && $urandom_range(0, 2) == 0) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0);
      check({tag, " valid"}, 32'(pcrc_out_valid), 32'd1);
      check({tag, " bit"}, 32'(pcrc_out_bit), 32'(exp_crc[12-j]));
      rx_bit = pcrc_out_bit;
      drive(1'b0, 1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b1, 2'd0);
      if (j < 12) n_early_done += int'(pcrc_done);
    end
    check({tag, " early done"}, 32'(n_early_done), 32'd0);
    check({tag, " done pulse"}, 32'(pcrc_done), 32'd1);
    check({tag, " valid drop"}, 32'(pcrc_out_valid), 32'd0);
    check({tag, " frozen frm"}, 32'(pcrc_frm), 32'(exp_crc));
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    check({tag, " done single"}, 32'(pcrc_done), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [12:0] bits;
    logic [12:0] exp_v;
    bit          msg[$];
    int          n_done;

    g_rst = 1'b1; rx_bit = 1'b0;
    initialize = 1'b0; pcrc_send = 1'b0; tx_bit_strobe = 1'b0; tx_bit = 1'b0;
    pcrc_enable = 1'b0; tx_success = 1'b0; rx_success = 1'b0; tx_abort = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset frm", 32'(pcrc_frm), 32'h0);
    check("reset valid", 32'(pcrc_out_valid), 32'd0);
    check("reset bit", 32'(pcrc_out_bit), 32'd0);
    check("reset done", 32'(pcrc_done), 32'd0);
    check("reset err", 32'(pcrc_bit_err), 32'd0);
    g_rst = 1'b0;

    // Directed table: bits 1,(gated 1),0 -> 0x0A49, then full serialization.
    bits = 13'h0A49;
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 13'h0000, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 13'h0000, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 13'h19C7, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 13'h19C7, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 13'h0A49, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 13'h0A49, 1'b1, bits[12], 1'b0));
    for (int j = 1; j < 13; j++)
      vecs.push_back(mk(1'b0, 1'b0, 1'b1, 1'(j), 1'b1, 2'd0, 13'h0A49, 1'b1, bits[12-j], 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 13'h0A49, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 13'h0A49, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 13'h0A49, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 13'h0A49, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 13'h0000, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 13'h0000, 1'b0, 1'b0, 1'b0));
    for (int j = 0; j < 4; j++)
      vecs.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 13'h0000, 1'b0, 1'b0, 1'b0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].ini, vecs[i].snd, vecs[i].stb, vecs[i].b, vecs[i].en, vecs[i].clr);
      check($sformatf("vec%0d frm", i), 32'(pcrc_frm), 32'(vecs[i].frm));
      check($sformatf("vec%0d valid", i), 32'(pcrc_out_valid), 32'(vecs[i].valid));
      check($sformatf("vec%0d bit", i), 32'(pcrc_out_bit), 32'(vecs[i].obit));
      check($sformatf("vec%0d done", i), 32'(pcrc_done), 32'(vecs[i].done));
    end

    // Strobes without enable, and enable without strobe, leave the CRC alone.
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd0);
    check("gated start", 32'(pcrc_frm), 32'h19C7);
    for (int j = 0; j < 10; j++) drive(1'b0, 1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b0, 2'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0);
    check("gated hold", 32'(pcrc_frm), 32'h19C7);

    // Send in the same cycle as an enabled strobe folds that bit in first.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2'd0);
    check("send+strobe frm", 32'(pcrc_frm), 32'h19C7);
    serialize_check("send+strobe", 13'h19C7, 1'b0);

    // tx_abort on the 5th SEND strobe: clear wins, no done pulse ever.
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd0);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd0);
    msg = '{1'b1, 1'b1};
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    check("abort pre frm", 32'(pcrc_frm), 32'(ref_crc(msg)));
    n_done = 0;
    for (int j = 0; j < 4; j++) drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd3);
    check("abort valid", 32'(pcrc_out_valid), 32'd0);
    check("abort frm", 32'(pcrc_frm), 32'h0);
    check("abort bit", 32'(pcrc_out_bit), 32'd0);
    for (int j = 0; j < 20; j++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd0);
      n_done += int'(pcrc_done) + int'(pcrc_out_valid);
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    n_done += int'(pcrc_out_valid);
    check("abort idle quiet", 32'(n_done), 32'd0);
    check("idle strobes frm", 32'(pcrc_frm), 32'h0);

    // initialize during SEND restarts accumulation.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2'd0);
    for (int j = 0; j < 3; j++) drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0);
    check("reinit valid", 32'(pcrc_out_valid), 32'd0);
    check("reinit frm", 32'(pcrc_frm), 32'h0);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd0);
    check("reinit accum", 32'(pcrc_frm), 32'h19C7);

    // Readback: corrupt the 3rd sent bit on the bus.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    for (int j = 0; j < 13; j++) begin
      rx_bit = (j == 2) ? ~pcrc_out_bit : pcrc_out_bit;
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0);
      if (j == 1 || j == 2 || j == 12)
        check($sformatf("readback err after bit %0d", j + 1), 32'(pcrc_bit_err),
              32'(READBACK && j >= 2));
    end
    check("readback done", 32'(pcrc_done), 32'd1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    check("readback err held", 32'(pcrc_bit_err), 32'(READBACK));
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    check("readback err cleared", 32'(pcrc_bit_err), 32'd0);

    // Random frames against the long-division model.
    for (int f = 0; f < 30; f++) begin
      msg.delete();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'(1 + (f % 2)));
      check($sformatf("rand%0d clear", f), 32'(pcrc_frm), 32'h0);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
      for (int k = $urandom_range(0, 24); k > 0; k--) begin
        logic b, en, stb;
        b = 1'($urandom_range(0, 1));
        en = 1'($urandom_range(0, 3) != 0);
        stb = 1'($urandom_range(0, 4) != 0);
        if (stb && en) msg.push_back(b);
        drive(1'b0, 1'b0, stb, b, en, 2'd0);
      end
      if ($urandom_range(0, 1) == 1) begin
        logic b;
        b = 1'($urandom_range(0, 1));
        msg.push_back(b);
        drive(1'b0, 1'b1, 1'b1, b, 1'b1, 2'd0);
      end else begin
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
      end
      exp_v = ref_crc(msg);
      check($sformatf("rand%0d frm", f), 32'(pcrc_frm), 32'(exp_v));
      serialize_check($sformatf("rand%0d", f), exp_v, 1'b1);
      check($sformatf("rand%0d err", f), 32'(pcrc_bit_err), 32'd0);
    end

    // Asynchronous reset in the middle of SEND.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0);
    #2;
    g_rst = 1'b1;
    #1;
    check("async rst frm", 32'(pcrc_frm), 32'h0);
    check("async rst valid", 32'(pcrc_out_valid), 32'd0);
    @(posedge clk);
    #1;
    g_rst = 1'b0;
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd0);
    check("post rst idle frm", 32'(pcrc_frm), 32'h0);
    check("post rst done", 32'(pcrc_done), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
